stream_resize: RTL

STREAM_RESIZE -- requirements
Module: stream_resize

---
 rtl/stream_resize.sv | 350 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/stream_resize.sv
`default_nettype none
// ============================================================================
// Module      : stream_resize
// Description : Streaming integer-factor image resizer for raster-order pixel
//               streams. Downscale averages FACTOR x FACTOR blocks through a
//               single line of accumulators. Upscale replicates pixels with
//               nearest-neighbour sampling from a one-row line buffer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      clock, all logic on the rising edge
//   rst        in   1      synchronous active-high reset
//   start      in   1      one-cycle frame request, accepted only in IDLE
//   scale      in   1      1 = upscale, 0 = downscale; sampled with start
//   in_valid   in   1      input pixel valid
//   in_data    in   PIX_W  input pixel
//   in_ready   out  1      input pixel accepted when in_valid && in_ready
//   out_valid  out  1      output pixel valid
//   out_data   out  PIX_W  output pixel
//   out_ready  in   1      downstream ready
//   out_last   out  1      marks the final output pixel of a frame
//   busy       out  1      frame in progress
//   finish     out  1      one-cycle pulse after the last output handshake
// ============================================================================
module stream_resize #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 410,
    parameter int IMG_H  = 361,
    parameter int FACTOR = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             scale,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             finish
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int c_OW    = IMG_W / FACTOR;
    localparam int c_OH    = IMG_H / FACTOR;
    localparam int c_FF    = FACTOR * FACTOR;
    localparam int c_ACC_W = PIX_W + $clog2(c_FF);
    localparam int c_XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_FW    = $clog2(FACTOR);
    // Block indices must also hold the value OW/OH, which marks the
    // trailing partial block column/row that is discarded.
    localparam int c_BXW   = $clog2(c_OW + 1);
    localparam int c_BYW   = $clog2(c_OH + 1);
    localparam int c_AIW   = (c_OW > 1) ? $clog2(c_OW) : 1;

    localparam logic [c_XW-1:0]    c_W_MAX  = c_XW'(IMG_W - 1);
    localparam logic [c_YW-1:0]    c_H_MAX  = c_YW'(IMG_H - 1);
    localparam logic [c_FW-1:0]    c_F_MAX  = c_FW'(FACTOR - 1);
    localparam logic [c_BXW-1:0]   c_OW_V   = c_BXW'(c_OW);
    localparam logic [c_BXW-1:0]   c_OW_M1  = c_BXW'(c_OW - 1);
    localparam logic [c_BYW-1:0]   c_OH_V   = c_BYW'(c_OH);
    localparam logic [c_BYW-1:0]   c_OH_M1  = c_BYW'(c_OH - 1);
    localparam logic [c_ACC_W-1:0] c_FF_V   = c_ACC_W'(c_FF);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DOWN    = 3'd1,
        S_UP_LOAD = 3'd2,
        S_UP_EMIT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;

    // Registered outputs
    logic                r_out_valid;
    logic [PIX_W-1:0]    r_out_data;
    logic                r_out_last;
    logic                r_busy;
    logic                r_finish;

    // Input raster position (shared by both modes)
    logic [c_XW-1:0]     r_col;
    logic [c_YW-1:0]     r_row;
    // Downscale: position inside the block and block index
    logic [c_FW-1:0]     r_fc;
    logic [c_FW-1:0]     r_fr;
    logic [c_BXW-1:0]    r_bx;
    logic [c_BYW-1:0]    r_by;
    logic                r_in_done;
    logic                r_out_done;
    // Upscale: replay position in the line buffer
    logic [c_XW-1:0]     r_ex;
    logic [c_FW-1:0]     r_sc;
    logic [c_FW-1:0]     r_sr;

    // Storage (no reset: first-pixel overwrite makes old contents harmless)
    logic [c_ACC_W-1:0]  r_acc  [c_OW];
    logic [PIX_W-1:0]    r_line [IMG_W];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_col_wrap;
    logic                w_row_wrap;
    logic                w_fc_wrap;
    logic                w_fr_wrap;
    logic                w_in_region;
    logic                w_blk_first;
    logic                w_blk_last;
    logic                w_frame_last;
    logic [c_AIW-1:0]    w_acc_idx;
    logic [c_ACC_W-1:0]  w_sum;
    logic [PIX_W-1:0]    w_avg;
    logic                w_in_done_nx;
    logic                w_out_done_nx;
    logic                w_sc_wrap;
    logic                w_ex_wrap;
    logic                w_sr_wrap;
    logic                w_row_end;
    logic [c_FW-1:0]     w_sc_nx;
    logic [c_XW-1:0]     w_ex_nx;
    logic [c_FW-1:0]     w_sr_nx;
    logic                w_emit_last;

    // Downscale accepts only when the single output register is free or
    // being drained this cycle, so no result is ever overwritten.
    assign w_in_ready = ((r_state == S_DOWN) && !r_in_done && (!r_out_valid || out_ready))
                      || (r_state == S_UP_LOAD);
    assign w_in_fire  = in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    assign w_col_wrap = (r_col == c_W_MAX);
    assign w_row_wrap = (r_row == c_H_MAX);
    assign w_fc_wrap  = (r_fc == c_F_MAX);
    assign w_fr_wrap  = (r_fr == c_F_MAX);

    assign w_in_region  = (r_bx < c_OW_V) && (r_by < c_OH_V);
    assign w_blk_first  = (r_fc == '0) && (r_fr == '0);
    assign w_blk_last   = w_fc_wrap && w_fr_wrap;
    assign w_frame_last = (r_bx == c_OW_M1) && (r_by == c_OH_M1);

    // Out-of-region block indices truncate here but are never written.
    assign w_acc_idx = c_AIW'(r_bx);
    assign w_sum     = r_acc[w_acc_idx] + c_ACC_W'(in_data);
    assign w_avg     = PIX_W'(w_sum / c_FF_V);

    assign w_in_done_nx  = r_in_done  || (w_in_fire && w_col_wrap && w_row_wrap);
    assign w_out_done_nx = r_out_done || (w_out_fire && r_out_last);

    // Upscale replay order: sub-column fastest, then buffer column, then
    // sub-row.
    assign w_sc_wrap = (r_sc == c_F_MAX);
    assign w_ex_wrap = (r_ex == c_W_MAX);
    assign w_sr_wrap = (r_sr == c_F_MAX);
    assign w_row_end = w_sc_wrap && w_ex_wrap && w_sr_wrap;

    assign w_sc_nx = w_sc_wrap ? '0 : r_sc + 1'b1;
    assign w_ex_nx = w_sc_wrap ? (w_ex_wrap ? '0 : r_ex + 1'b1) : r_ex;
    assign w_sr_nx = (w_sc_wrap && w_ex_wrap) ? (w_sr_wrap ? '0 : r_sr + 1'b1) : r_sr;

    assign w_emit_last = (r_row == c_H_MAX) && (w_sr_nx == c_F_MAX)
                      && (w_ex_nx == c_W_MAX) && (w_sc_nx == c_F_MAX);

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_fc        <= '0;
            r_fr        <= '0;
            r_bx        <= '0;
            r_by        <= '0;
            r_in_done   <= 1'b0;
            r_out_done  <= 1'b0;
            r_ex        <= '0;
            r_sc        <= '0;
            r_sr        <= '0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_fc       <= '0;
                        r_fr       <= '0;
                        r_bx       <= '0;
                        r_by       <= '0;
                        r_in_done  <= 1'b0;
                        r_out_done <= 1'b0;
                        r_ex       <= '0;
                        r_sc       <= '0;
                        r_sr       <= '0;
                        r_state    <= scale ? S_UP_LOAD : S_DOWN;
                    end
                end

                S_DOWN: begin
                    // Drain first; a same-cycle new result below overrides.
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                    if (w_in_fire) begin
                        if (w_in_region && w_blk_last) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_avg;
                            r_out_last  <= w_frame_last;
                        end
                        if (w_col_wrap) begin
                            r_col <= '0;
                            r_fc  <= '0;
                            r_bx  <= '0;
                            if (w_row_wrap) begin
                                r_row <= '0;
                                r_fr  <= '0;
                                r_by  <= '0;
                            end else begin
                                r_row <= r_row + 1'b1;
                                if (w_fr_wrap) begin
                                    r_fr <= '0;
                                    r_by <= r_by + 1'b1;
                                end else begin
                                    r_fr <= r_fr + 1'b1;
                                end
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                            if (w_fc_wrap) begin
                                r_fc <= '0;
                                r_bx <= r_bx + 1'b1;
                            end else begin
                                r_fc <= r_fc + 1'b1;
                            end
                        end
                    end
                    r_in_done  <= w_in_done_nx;
                    r_out_done <= w_out_done_nx;
                    // Trailing discarded pixels may arrive after the last
                    // output, so both conditions gate completion.
                    if (w_in_done_nx && w_out_done_nx) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_finish <= 1'b1;
                    end
                end

                S_UP_LOAD: begin
                    if (w_in_fire) begin
                        if (w_col_wrap) begin
                            r_col       <= '0;
                            r_ex        <= '0;
                            r_sc        <= '0;
                            r_sr        <= '0;
                            r_state     <= S_UP_EMIT;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                            // Column 0 is being written this cycle only for a
                            // single-pixel row.
                            r_out_data  <= (r_col == '0) ? in_data : r_line[0];
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end

                S_UP_EMIT: begin
                    if (w_out_fire) begin
                        r_sc <= w_sc_nx;
                        r_ex <= w_ex_nx;
                        r_sr <= w_sr_nx;
                        if (w_row_end) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (w_row_wrap) begin
                                r_row    <= '0;
                                r_state  <= S_DONE;
                                r_busy   <= 1'b0;
                                r_finish <= 1'b1;
                            end else begin
                                r_row   <= r_row + 1'b1;
                                r_state <= S_UP_LOAD;
                            end
                        end else begin
                            r_out_data <= r_line[w_ex_nx];
                            r_out_last <= w_emit_last;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator line: first pixel of a block overwrites, the rest add
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((r_state == S_DOWN) && w_in_fire && w_in_region) begin
            r_acc[w_acc_idx] <= w_blk_first ? c_ACC_W'(in_data) : w_sum;
        end
    end

    // ------------------------------------------------------------------------
    // Upscale line buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((r_state == S_UP_LOAD) && in_valid) begin
            r_line[r_col] <= in_data;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign finish    = r_finish;

endmodule
`default_nettype wire
